// File: rtl/alu_operand_stage_if.sv
// Handshake bundle between the issue logic, the operand stage and the ALU.
// It carries the issue side, the writeback port and the registered operand bundle.
interface alu_operand_stage_if #(
    parameter int W   = 8,
    parameter int Ops = 3,
    parameter int RA  = 3
);
    logic           in_valid;
    logic           in_ready;
    logic [Ops-1:0] in_op;
    logic [RA-1:0]  in_ra;
    logic [RA-1:0]  in_rb;
    logic [RA-1:0]  in_rc;
    logic [RA-1:0]  in_rd;
    logic           in_imm_sel;
    logic [W-1:0]   in_imm;

    logic           wb_en;
    logic [RA-1:0]  wb_addr;
    logic [W-1:0]   wb_data;

    logic           out_valid;
    logic           out_ready;
    logic [Ops-1:0] out_op;
    logic [W-1:0]   out_a;
    logic [W-1:0]   out_b;
    logic [W-1:0]   out_c;
    logic [RA-1:0]  out_rd;

    modport master (
        output in_valid, in_op, in_ra, in_rb, in_rc, in_rd, in_imm_sel, in_imm,
        output wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_op, out_a, out_b, out_c, out_rd
    );

    modport slave (
        input  in_valid, in_op, in_ra, in_rb, in_rc, in_rd, in_imm_sel, in_imm,
        input  wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_op, out_a, out_b, out_c, out_rd
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: register file, writeback bypass, immediate select and a
// registered valid/ready operand bundle that keeps held operands coherent with writebacks.
module alu_operand_stage #(
    parameter int W   = 8,
    parameter int Ops = 3,
    parameter int RA  = 3
) (
    input  logic               clk,
    input  logic               reset,
    alu_operand_stage_if.slave bus
);
    localparam int N = 1 << RA;

    logic [W-1:0] rf_rdata [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rf
            logic [W-1:0] entry_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_q <= '0;
                end else if (bus.wb_en && (bus.wb_addr == RA'(gi))) begin
                    entry_q <= bus.wb_data;
                end
            end
            assign rf_rdata[gi] = entry_q;
        end
    endgenerate

    // Bypass makes a same-cycle writeback visible to the op being captured.
    logic [W-1:0] rd_a, rd_b, rd_c;
    assign rd_a = (bus.wb_en && bus.wb_addr == bus.in_ra) ? bus.wb_data : rf_rdata[bus.in_ra];
    assign rd_b = (bus.wb_en && bus.wb_addr == bus.in_rb) ? bus.wb_data : rf_rdata[bus.in_rb];
    assign rd_c = (bus.wb_en && bus.wb_addr == bus.in_rc) ? bus.wb_data : rf_rdata[bus.in_rc];

    logic           out_valid_q, out_valid_d;
    logic [Ops-1:0] op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   c_q, c_d;
    logic [RA-1:0]  rd_q, rd_d;
    logic [RA-1:0]  hold_ra_q, hold_ra_d;
    logic [RA-1:0]  hold_rb_q, hold_rb_d;
    logic [RA-1:0]  hold_rc_q, hold_rc_d;
    logic           hold_bimm_q, hold_bimm_d;

    logic xfer;
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign xfer         = bus.in_valid && bus.in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        rd_d        = rd_q;
        hold_ra_d   = hold_ra_q;
        hold_rb_d   = hold_rb_q;
        hold_rc_d   = hold_rc_q;
        hold_bimm_d = hold_bimm_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            op_d        = bus.in_op;
            a_d         = rd_a;
            b_d         = bus.in_imm_sel ? bus.in_imm : rd_b;
            c_d         = rd_c;
            rd_d        = bus.in_rd;
            hold_ra_d   = bus.in_ra;
            hold_rb_d   = bus.in_rb;
            hold_rc_d   = bus.in_rc;
            hold_bimm_d = bus.in_imm_sel;
        end else if (out_valid_q) begin
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            // A held bundle must not carry a stale register value past a writeback.
            if (bus.wb_en) begin
                if (hold_ra_q == bus.wb_addr) a_d = bus.wb_data;
                if (!hold_bimm_q && hold_rb_q == bus.wb_addr) b_d = bus.wb_data;
                if (hold_rc_q == bus.wb_addr) c_d = bus.wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            rd_q        <= '0;
            hold_ra_q   <= '0;
            hold_rb_q   <= '0;
            hold_rc_q   <= '0;
            hold_bimm_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            rd_q        <= rd_d;
            hold_ra_q   <= hold_ra_d;
            hold_rb_q   <= hold_rb_d;
            hold_rc_q   <= hold_rc_d;
            hold_bimm_q <= hold_bimm_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = op_q;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_c     = c_q;
    assign bus.out_rd    = rd_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the operand stage.
module tb_alu_operand_stage;
    localparam int W   = 8;
    localparam int Ops = 3;
    localparam int RA  = 3;
    localparam int N   = 1 << RA;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.W(W), .Ops(Ops), .RA(RA)) bus ();

    alu_operand_stage #(.W(W), .Ops(Ops), .RA(RA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: register file contents and the bundle as the ALU sees it.
    typedef struct {
        logic           valid;
        logic [Ops-1:0] op;
        logic [W-1:0]   a, b, c;
        logic [RA-1:0]  rd;
        logic [RA-1:0]  src_a, src_b, src_c;
        logic           b_is_imm;
    } bundle_t;

    logic [W-1:0] m_rf [N];
    bundle_t      m_out;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] reg_value(input logic [RA-1:0] r);
        if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
        return m_rf[r];
    endfunction

    task automatic model_step();
        bundle_t nxt;
        logic    accept;
        nxt    = m_out;
        accept = bus.in_valid && (!m_out.valid || bus.out_ready);
        if (reset) begin
            foreach (m_rf[i]) m_rf[i] = '0;
            nxt = '{default: '0};
        end else begin
            if (accept) begin
                nxt.valid    = 1'b1;
                nxt.op       = bus.in_op;
                nxt.a        = reg_value(bus.in_ra);
                nxt.b        = bus.in_imm_sel ? bus.in_imm : reg_value(bus.in_rb);
                nxt.c        = reg_value(bus.in_rc);
                nxt.rd       = bus.in_rd;
                nxt.src_a    = bus.in_ra;
                nxt.src_b    = bus.in_rb;
                nxt.src_c    = bus.in_rc;
                nxt.b_is_imm = bus.in_imm_sel;
                $display("xfer cyc=%0d op=%0d a=%02h b=%02h c=%02h rd=%0d",
                         cyc, nxt.op, nxt.a, nxt.b, nxt.c, nxt.rd);
            end else if (m_out.valid) begin
                if (bus.out_ready) nxt.valid = 1'b0;
                if (bus.wb_en && m_out.src_a == bus.wb_addr) nxt.a = bus.wb_data;
                if (bus.wb_en && !m_out.b_is_imm && m_out.src_b == bus.wb_addr) nxt.b = bus.wb_data;
                if (bus.wb_en && m_out.src_c == bus.wb_addr) nxt.c = bus.wb_data;
            end
            if (bus.wb_en) m_rf[bus.wb_addr] = bus.wb_data;
        end
        m_out = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_out.valid));
        check_eq("in_ready",  32'(bus.in_ready),  32'(!m_out.valid || bus.out_ready));
        check_eq("out_op",    32'(bus.out_op),    32'(m_out.op));
        check_eq("out_a",     32'(bus.out_a),     32'(m_out.a));
        check_eq("out_b",     32'(bus.out_b),     32'(m_out.b));
        check_eq("out_c",     32'(bus.out_c),     32'(m_out.c));
        check_eq("out_rd",    32'(bus.out_rd),    32'(m_out.rd));
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_op      = '0;
        bus.in_ra      = '0;
        bus.in_rb      = '0;
        bus.in_rc      = '0;
        bus.in_rd      = '0;
        bus.in_imm_sel = 1'b0;
        bus.in_imm     = '0;
        bus.wb_en      = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_data    = '0;
    endtask

    logic [W-1:0] held_a;

    initial begin
        foreach (m_rf[i]) m_rf[i] = 'x;
        m_out = '{default: 'x};
        idle_inputs();
        bus.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state read back through a first issue.
        bus.in_valid = 1'b1; bus.in_ra = 3'd1; bus.in_rb = 3'd2; bus.in_rc = 3'd3;
        bus.in_op = 3'd5; bus.in_rd = 3'd6;
        check_eq("ready_after_reset", 32'(bus.in_ready), 32'd1);
        tick();
        check_eq("t1_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t1_abc", {8'h0, bus.out_a, bus.out_b, bus.out_c}, 32'h0);
        idle_inputs();
        tick();

        // Writeback then immediate issue.
        bus.wb_en = 1'b1; bus.wb_addr = 3'd1; bus.wb_data = 8'h3C;
        tick();
        idle_inputs();
        bus.in_valid = 1'b1; bus.in_ra = 3'd1; bus.in_imm_sel = 1'b1; bus.in_imm = 8'h02;
        tick();
        check_eq("t2_a", 32'(bus.out_a), 32'h3C);
        check_eq("t2_b", 32'(bus.out_b), 32'h02);

        // Same-cycle bypass, then confirm the stored value.
        idle_inputs();
        bus.wb_en = 1'b1; bus.wb_addr = 3'd4; bus.wb_data = 8'hA5;
        bus.in_valid = 1'b1; bus.in_ra = 3'd4; bus.in_rc = 3'd4;
        tick();
        check_eq("t3_a", 32'(bus.out_a), 32'hA5);
        check_eq("t3_c", 32'(bus.out_c), 32'hA5);
        idle_inputs();
        bus.in_valid = 1'b1; bus.in_rb = 3'd4;
        tick();
        check_eq("t3_rf4", 32'(bus.out_b), 32'hA5);

        // Stall: held bundle stays put, pending op waits, then goes in as it drains.
        idle_inputs();
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = 3'd2; bus.in_ra = 3'd1;
        tick();
        held_a = bus.out_a;
        bus.in_op = 3'd3; bus.in_ra = 3'd4;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_ready", 32'(bus.in_ready), 32'd0);
            tick();
            check_eq("stall_a", 32'(bus.out_a), 32'(held_a));
            check_eq("stall_op", 32'(bus.out_op), 32'd2);
        end
        bus.out_ready = 1'b1;
        tick();
        check_eq("drain_op", 32'(bus.out_op), 32'd3);
        check_eq("drain_a", 32'(bus.out_a), 32'hA5);

        // Hold refresh on A while B came from an immediate naming the same register.
        idle_inputs();
        tick();
        bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 8'h10;
        tick();
        idle_inputs();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_ra = 3'd2; bus.in_rb = 3'd2; bus.in_imm_sel = 1'b1; bus.in_imm = 8'h55;
        tick();
        check_eq("hr_a_before", 32'(bus.out_a), 32'h10);
        idle_inputs();
        bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 8'h77;
        tick();
        check_eq("hr_a_after", 32'(bus.out_a), 32'h77);
        check_eq("hr_b_imm", 32'(bus.out_b), 32'h55);

        // Reset mid-stall discards the bundle and the concurrent writeback.
        bus.wb_addr = 3'd3; bus.wb_data = 8'h99;
        reset = 1'b1;
        tick();
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_ra = 3'd3;
        tick();
        check_eq("rst_r3", 32'(bus.out_a), 32'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid   = ($urandom_range(0, 9) < 7);
            bus.in_op      = Ops'($urandom);
            bus.in_ra      = RA'($urandom);
            bus.in_rb      = RA'($urandom);
            bus.in_rc      = RA'($urandom);
            bus.in_rd      = RA'($urandom);
            bus.in_imm_sel = $urandom_range(0, 3) == 0;
            bus.in_imm     = W'($urandom);
            bus.wb_en      = $urandom_range(0, 1) == 1;
            bus.wb_addr    = RA'($urandom);
            bus.wb_data    = W'($urandom);
            bus.out_ready  = ($urandom_range(0, 9) < 6);
            reset          = ($urandom_range(0, 99) < 2);
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch pipeline stage directly upstream of the 8-bit ALU.
- Holds the architectural register file and reads the A, B and C operands for each issued op.
- Applies writeback bypass and immediate selection, then presents a registered operand bundle to the ALU through a valid/ready handshake.
- Accepts the ALU result back as the writeback port.

Parameters:
- W, 8, datapath width; must match the ALU width.
- Ops, 3, opcode width; must match the ALU OP width.
- RA, 3, register address width; the register file has 2**RA entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has an op to issue.
- in_ready  out  1  stage can accept an op this cycle.
- in_op  in  Ops  opcode, passed through unchanged.
- in_ra  in  RA  source register for A.
- in_rb  in  RA  source register for B.
- in_rc  in  RA  source register for C (compare operand).
- in_rd  in  RA  destination register, passed through.
- in_imm_sel  in  1  when 1, B comes from in_imm instead of in_rb.
- in_imm  in  W  immediate value.
- wb_en  in  1  write the register file this cycle.
- wb_addr  in  RA  writeback register.
- wb_data  in  W  writeback value (ALU out).
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  ALU side consumes the bundle this cycle.
- out_op  out  Ops  registered opcode.
- out_a  out  W  registered A operand.
- out_b  out  W  registered B operand.
- out_c  out  W  registered C operand.
- out_rd  out  RA  registered destination.

Behaviour:
- Reset:
  - All 2**RA registers clear to 0.
  - out_valid, out_op, out_a, out_b, out_c and out_rd clear to 0.
  - Reset takes priority over everything: a wb_en or a handshake in the same cycle is discarded.
  - A reset asserted while a bundle is stalled drops that bundle.
- Register file write:
  - When wb_en=1, wb_data is written to entry wb_addr at the clock edge.
  - Every entry is writable; there is no hardwired zero register.
- Read and bypass (combinational, during the capture cycle):
  - A = (wb_en && wb_addr==in_ra) ? wb_data : rf[in_ra].
  - C uses the same rule with in_rc.
  - B uses the same rule with in_rb, except B = in_imm when in_imm_sel=1.
  - Bypass wins over the stored value, so the captured operand equals the post-write value.
- Handshake:
  - in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
  - A transfer occurs when in_valid && in_ready. On transfer, capture op, a, b, c, rd and set out_valid=1.
  - When out_valid && out_ready and there is no new transfer, out_valid becomes 0 at the next edge. Payload registers hold their last value.
  - Back-to-back operation: with out_ready held at 1, one op is accepted per cycle and latency is exactly 1 cycle (input to out_*).
  - While out_valid && !out_ready, all out_* payload fields are stable, except for the hold-refresh rule below.
- Hold refresh (stall hazard):
  - Applies while out_valid=1 and no new transfer occurs this cycle.
  - A wb_en targeting the register a held operand was read from updates that operand register with wb_data.
  - The stage keeps hold_ra, hold_rb, hold_rc and hold_bimm (the B-was-immediate flag) for this purpose. B is never refreshed when hold_bimm=1.
  - If several held operands came from the same register, all of them refresh.
- Simultaneous events:
  - A transfer and a wb_en in the same cycle: the new bundle gets bypassed data, and the old bundle is discarded (it was consumed).
  - ra==rb==rc is legal; each operand gets the same value.
- Arithmetic: no arithmetic in this stage; all values pass through unmodified at width W.

Test Plan:
- Reset, then issue ra=1, rb=2, rc=3 with out_ready=1 -> next cycle out_valid=1 and out_a=out_b=out_c=0. in_ready stays 1 throughout.
- Write wb r1=8'h3C, then next cycle issue ra=1, in_imm_sel=1, in_imm=8'h02 -> out_a=8'h3C, out_b=8'h02.
- Same-cycle bypass: wb_en r4=8'hA5 together with an issue of ra=4, rc=4 -> out_a=out_c=8'hA5, and rf[4]=8'hA5 afterwards.
- Stall: out_ready=0 with a bundle held -> in_ready=0, a new in_valid is not accepted and out_* are stable for 5 cycles. Then out_ready=1 -> the held bundle drains and the pending op is accepted that same cycle.
- Hold refresh: bundle held with ra=2 (value 8'h10) and B from an immediate with rb field=2; wb r2=8'h77 -> out_a becomes 8'h77 next cycle and out_b keeps the immediate.
- Reset mid-stall with out_valid=1 and wb_en=1 -> next cycle out_valid=0, the written register reads 0 and in_ready=1.
